// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - SAP controller opcodes, one-hot T-states and control-word layout
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int CW_W  = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  // Active-low lines idle high, active-high lines idle low.
  localparam logic [CW_W-1:0] CTRL_IDLE = 12'h3E3;

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - six-state one-hot falling-edge ring with hold and restart
import sap_pkg::*;

module sap_ring_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       restart,
  output logic [5:0] t_state
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      t_state <= T1;
    end else if (hold) begin
      t_state <= t_state;
    end else if (restart) begin
      t_state <= T1;
    end else begin
      t_state <= {t_state[4:0], t_state[5]};
    end
  end

endmodule

// File: rtl/sap_controller.sv
// rtl/sap_controller.sv - SAP sequencer and control-word decode; SAP_EARLY_END_EN shortens LDA/OUT/NOP
import sap_pkg::*;

module sap_controller #(
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            async_reset,
  input  logic [OP_W-1:0] opcode,
  output logic            pc_inc,
  output logic            pc_out_en,
  output logic            low_mar_i_en,
  output logic            low_ram_o_en,
  output logic            low_ir_i_en,
  output logic            low_ir_o_en,
  output logic            low_acc_i_en,
  output logic            acc_out_en,
  output logic            alu_sub,
  output logic            alu_out_en,
  output logic            low_b_i_en,
  output logic            low_out_i_en,
  output logic            halt,
  output logic [5:0]      t_state
);

  logic            is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
  logic            hold, restart;
  logic [CW_W-1:0] cw;

  assign is_lda = (opcode == OP_W'(OP_LDA));
  assign is_add = (opcode == OP_W'(OP_ADD));
  assign is_sub = (opcode == OP_W'(OP_SUB));
  assign is_out = (opcode == OP_W'(OP_OUT));
  assign is_hlt = (opcode == OP_W'(OP_HLT));
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

  // The ring freezes in T4 on the same edge that sets halt.
  assign hold = halt || ((t_state == T4) && is_hlt);

`ifdef SAP_EARLY_END_EN
  assign restart = ((t_state == T5) && is_lda) ||
                   ((t_state == T4) && is_out) ||
                   ((t_state == T3) && is_nop);
`else
  assign restart = 1'b0;
`endif

  sap_ring_counter u_ring (
    .clk     (clk),
    .rst     (async_reset),
    .hold    (hold),
    .restart (restart),
    .t_state (t_state)
  );

  always_ff @(negedge clk or posedge async_reset) begin
    if (async_reset) begin
      halt <= 1'b0;
    end else if ((t_state == T4) && is_hlt) begin
      halt <= 1'b1;
    end
  end

  always_comb begin
    cw = CTRL_IDLE;
    if (!halt) begin
      if (t_state == T1) begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b0;
      end
      if (t_state == T2) begin
        cw[CW_CP] = 1'b1;
      end
      if (t_state == T3) begin
        cw[CW_CE] = 1'b0;
        cw[CW_LI] = 1'b0;
      end
      if (t_state == T4) begin
        if (is_lda || is_add || is_sub) begin
          cw[CW_EI] = 1'b0;
          cw[CW_LM] = 1'b0;
        end else if (is_out) begin
          cw[CW_EA] = 1'b1;
          cw[CW_LO] = 1'b0;
        end
      end
      if (t_state == T5) begin
        if (is_lda) begin
          cw[CW_CE] = 1'b0;
          cw[CW_LA] = 1'b0;
        end else if (is_add || is_sub) begin
          cw[CW_CE] = 1'b0;
          cw[CW_LB] = 1'b0;
          cw[CW_SU] = is_sub;
        end
      end
      // Su is held through T6 so the ALU output has settled before Eu.
      if ((t_state == T6) && (is_add || is_sub)) begin
        cw[CW_EU] = 1'b1;
        cw[CW_LA] = 1'b0;
        cw[CW_SU] = is_sub;
      end
    end
  end

  assign pc_inc       = cw[CW_CP];
  assign pc_out_en    = cw[CW_EP];
  assign low_mar_i_en = cw[CW_LM];
  assign low_ram_o_en = cw[CW_CE];
  assign low_ir_i_en  = cw[CW_LI];
  assign low_ir_o_en  = cw[CW_EI];
  assign low_acc_i_en = cw[CW_LA];
  assign acc_out_en   = cw[CW_EA];
  assign alu_sub      = cw[CW_SU];
  assign alu_out_en   = cw[CW_EU];
  assign low_b_i_en   = cw[CW_LB];
  assign low_out_i_en = cw[CW_LO];

  a_bus_contention: assert property (@(posedge clk) disable iff (async_reset)
    $onehot0({pc_out_en, !low_ram_o_en, !low_ir_o_en, acc_out_en, alu_out_en}));

endmodule

// File: tb/tb_sap_controller.sv
// tb/tb_sap_controller.sv - directed and random checks of the SAP sequencer
module tb_sap_controller;

  logic       clk;
  logic       async_reset;
  logic [3:0] opcode;
  logic       pc_inc, pc_out_en, low_mar_i_en, low_ram_o_en, low_ir_i_en, low_ir_o_en;
  logic       low_acc_i_en, acc_out_en, alu_sub, alu_out_en, low_b_i_en, low_out_i_en;
  logic       halt;
  logic [5:0] t_state;

  int n_tests = 0;
  int n_fail  = 0;

  sap_controller #(.OP_W(4)) dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .opcode       (opcode),
    .pc_inc       (pc_inc),
    .pc_out_en    (pc_out_en),
    .low_mar_i_en (low_mar_i_en),
    .low_ram_o_en (low_ram_o_en),
    .low_ir_i_en  (low_ir_i_en),
    .low_ir_o_en  (low_ir_o_en),
    .low_acc_i_en (low_acc_i_en),
    .acc_out_en   (acc_out_en),
    .alu_sub      (alu_sub),
    .alu_out_en   (alu_out_en),
    .low_b_i_en   (low_b_i_en),
    .low_out_i_en (low_out_i_en),
    .halt         (halt),
    .t_state      (t_state)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Bench order: Cp Ep ~Lm ~CE ~Li ~Ei ~La Ea Su Eu ~Lb ~Lo
  function automatic logic [11:0] cw_now();
    return {pc_inc, pc_out_en, low_mar_i_en, low_ram_o_en, low_ir_i_en, low_ir_o_en,
            low_acc_i_en, acc_out_en, alu_sub, alu_out_en, low_b_i_en, low_out_i_en};
  endfunction

  function automatic logic [11:0] exp_cw(input logic [3:0] op, input int k);
    logic [11:0] w;
    w = 12'h3E3;
    case (k)
      0: w = 12'h5E3;
      1: w = 12'hBE3;
      2: w = 12'h263;
      3: case (op)
           4'b0000, 4'b0001, 4'b0010: w = 12'h1A3;
           4'b1110:                   w = 12'h3F2;
           default:                   w = 12'h3E3;
         endcase
      4: case (op)
           4'b0000: w = 12'h2C3;
           4'b0001: w = 12'h2E1;
           4'b0010: w = 12'h2E9;
           default: w = 12'h3E3;
         endcase
      5: case (op)
           4'b0001: w = 12'h3C7;
           4'b0010: w = 12'h3CF;
           default: w = 12'h3E3;
         endcase
      default: w = 12'h3E3;
    endcase
    return w;
  endfunction

  function automatic int instr_len(input logic [3:0] op);
`ifdef SAP_EARLY_END_EN
    case (op)
      4'b0000: return 5;
      4'b1110: return 4;
      4'b0001, 4'b0010: return 6;
      default: return 3;
    endcase
`else
    return 6;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input string name);
    logic [5:0] exp_t;
    opcode = op;
    for (int k = 0; k < instr_len(op); k++) begin
      exp_t = 6'b000001 << k;
      check($sformatf("%s_t%0d_state", name, k + 1), t_state, exp_t);
      check($sformatf("%s_t%0d_cw", name, k + 1), cw_now(), exp_cw(op, k));
      step();
    end
    check($sformatf("%s_wrap", name), t_state, 6'b000001);
  endtask

  initial begin
    int drv;
    async_reset = 1'b1;
    opcode      = 4'b0000;
    repeat (3) step();
    check("rst_state", t_state, 6'b000001);
    check("rst_halt", halt, 1'b0);
    check("rst_cw", cw_now(), 12'h5E3);
    async_reset = 1'b0;

    run_instr(4'b0000, "lda");
    run_instr(4'b0001, "add");
    run_instr(4'b0010, "sub");
    run_instr(4'b1110, "out");
    run_instr(4'b0101, "nop");

    // Reset mid-instruction abandons it; next falling edge goes to T2.
    opcode = 4'b0000;
    repeat (4) step();
    check("mid_pre_state", t_state, 6'b010000);
    async_reset = 1'b1;
    #1;
    check("mid_rst_state", t_state, 6'b000001);
    check("mid_rst_cw", cw_now(), 12'h5E3);
    step();
    async_reset = 1'b0;
    step();
    check("mid_rel_state", t_state, 6'b000010);
    repeat (5) step();
    check("mid_wrap", t_state, 6'b000001);

    opcode = 4'b1111;
    repeat (3) step();
    check("hlt_t4_state", t_state, 6'b001000);
    check("hlt_t4_halt", halt, 1'b0);
    check("hlt_t4_cw", cw_now(), 12'h3E3);
    for (int i = 0; i < 12; i++) begin
      step();
      check("hlt_halt", halt, 1'b1);
      check("hlt_state", t_state, 6'b001000);
      check("hlt_cw", cw_now(), 12'h3E3);
    end
    opcode = 4'b0000;
    step();
    check("hlt_sticky", halt, 1'b1);
    async_reset = 1'b1;
    #1;
    check("hlt_rst_state", t_state, 6'b000001);
    check("hlt_rst_halt", halt, 1'b0);
    check("hlt_rst_cw", cw_now(), 12'h5E3);
    step();
    async_reset = 1'b0;

    for (int i = 0; i < 200; i++) begin
      opcode = 4'($urandom_range(0, 14));
      step();
      check("rand_onehot", $onehot(t_state), 1'b1);
      drv = int'(pc_out_en) + int'(!low_ram_o_en) + int'(!low_ir_o_en)
          + int'(acc_out_en) + int'(alu_out_en);
      check("rand_bus", drv <= 1, 1'b1);
      check("rand_nohalt", halt, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
